// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds PS/2 set-2 E0/F0 prefixes into key events and queues them.
// Frames are parity-checked; status bytes are discarded without disturbing prefix state.
module ps2_scancode_decoder #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       rdy,
    input  logic [8:0] frame,
    input  logic       evt_rd,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_rel,
    output logic       parity_err,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t state, state_n;
    logic rdy_m, rdy_s, rdy_d, armed, pulse;
    logic [1:0] warm;
    logic [8:0] frame_q;
    logic [7:0] b;
    logic odd, status, push_req, push_ext, push_rel, full, empty, pop, push;
    logic [AW:0] wptr, rptr;
    logic [9:0] mem [DEPTH];
    // armed stays low until rdy is seen low after reset, so a level held across reset is not an edge
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rdy_m   <= 1'b0;
            rdy_s   <= 1'b0;
            rdy_d   <= 1'b0;
            warm    <= 2'b00;
            armed   <= 1'b0;
            pulse   <= 1'b0;
            frame_q <= '0;
        end else begin
            rdy_m   <= rdy;
            rdy_s   <= rdy_m;
            rdy_d   <= rdy_s;
            warm    <= {warm[0], 1'b1};
            armed   <= armed | (warm[1] & ~rdy_s);
            pulse   <= rdy_s & ~rdy_d & armed & en;
            if (rdy_s & ~rdy_d) frame_q <= frame;
        end
    end
    assign b        = frame_q[7:0];
    assign odd      = ^frame_q;
    assign status   = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    assign push_ext = (state == EXT) || (state == EXT_BRK);
    assign push_rel = (state == BRK) || (state == EXT_BRK);
    always_comb begin
        state_n  = state;
        push_req = 1'b0;
        if (pulse) begin
            if (!odd) begin
                state_n = IDLE;
            end else if (!status) begin
                if (b == 8'hE0) begin
                    state_n = (state == EXT_BRK) ? EXT_BRK : EXT;
                end else if (b == 8'hF0) begin
                    state_n = push_ext ? EXT_BRK : BRK;
                end else begin
                    push_req = 1'b1;
                    state_n  = IDLE;
                end
            end
        end
    end
    assign empty = (wptr == rptr);
    assign full  = (wptr == {~rptr[AW], rptr[AW-1:0]});
    assign pop   = evt_rd & ~empty;
    assign push  = push_req & (~full | pop);
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            parity_err <= pulse & ~odd;
            overflow   <= push_req & full & ~pop;
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem[wptr[AW-1:0]] <= {push_ext, push_rel, b};
    end
    assign evt_valid = ~empty;
    assign {evt_ext, evt_rel, evt_code} = empty ? 10'h000 : mem[rptr[AW-1:0]];
endmodule
